uart_apb_regif: RTL
===================

# uart_apb_regif

APB3 slave register front-end for the UART physical layer. It converts CPU register accesses into write-side pushes on the TX-byte FIFO and the config FIFO, and into read-side pops on the RX-byte FIFO. Those three FIFOs feed the UART PHY. It also keeps status and sticky error bits, and drives a level interrupt.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 8: APB address width. Only bits [4:2] are decoded.
- `PHY_FIFO_WIDTH`, default 8: UART data byte width.
- `CONFIG_DATA_WIDTH`, default 40: config word width. Must be between 33 and 64.

**Ports** (clock and reset first)
- `clk` in 1: single clock for all logic.
- `rstn` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1 each: APB3 control.
- `paddr` in `ADDR_WIDTH`: byte address.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: transfer completes.
- `pslverr` out 1: transfer error.
- `tx_fifo_full` in 1, `tx_fifo_empty` in 1: TX-byte FIFO flags.
- `tx_fifo_wr_en` out 1: TX-byte FIFO push strobe.
- `tx_fifo_wr_data` out `PHY_FIFO_WIDTH`: TX-byte FIFO push data.
- `cfg_fifo_full` in 1: config FIFO full flag.
- `cfg_fifo_wr_en` out 1: config FIFO push strobe.
- `cfg_fifo_wr_data` out `CONFIG_DATA_WIDTH`: config FIFO push data.
- `rx_fifo_empty` in 1: RX-byte FIFO empty flag.
- `rx_fifo_rd_en` out 1: RX-byte FIFO pop strobe.
- `rx_fifo_rd_data` in `PHY_FIFO_WIDTH`: valid one cycle after `rx_fifo_rd_en`.
- `irq` out 1: level interrupt.

## Operation

**Register map** (offset is `paddr[4:2]`×4)
- 0x00 TXDATA, write-only.
  - If `tx_fifo_full`=0: push `pwdata[7:0]`.
  - If full: no push, `pslverr`=1, TX_OVF set.
  - Reads return 0.
- 0x04 RXDATA, read-only.
  - If `rx_fifo_empty`=0: pop one byte, return it zero-extended.
  - If empty: `prdata`=0, `pslverr`=1, no pop.
  - Writes are ignored with no error.
- 0x08 CFG_LO, read/write: staging register for config bits [31:0]. Writing it does not push.
- 0x0C CFG_HI, read/write: staging register for config bits [CONFIG_DATA_WIDTH-1:32].
  - A write commits `{pwdata[CONFIG_DATA_WIDTH-33:0], CFG_LO}` to the config FIFO.
  - If `cfg_fifo_full`: CFG_HI is still updated, but there is no push, `pslverr`=1, and CFG_OVF is set.
- 0x10 STATUS, read-only:
  - bit0 `tx_fifo_full`, bit1 `tx_fifo_empty`, bit2 `rx_fifo_empty`, bit3 `cfg_fifo_full`
  - bit4 TX_OVF, bit5 CFG_OVF, bit6 RX_UNF (RXDATA read while empty)
- 0x14 CTRL, read/write: bit0 RX_IE, bit1 TX_IE. Writing 1 to bits 4–6 clears the matching sticky bit (write-1-to-clear).
- 0x18 and 0x1C: reads return 0, writes are ignored, `pslverr`=0.

**Interrupt**
- `irq` = (RX_IE & ~`rx_fifo_empty`) | (TX_IE & `tx_fifo_empty`), registered.

**FSM states:** IDLE, RX_POP, RX_CAP.
- IDLE:
  - On `psel`&~`penable`, the transfer is decoded.
  - A non-empty RXDATA read goes to RX_POP.
  - Every other access is served zero-wait in the ACCESS cycle.
- RX_POP: `rx_fifo_rd_en`=1 for exactly one cycle, `pready`=0. Go to RX_CAP.
- RX_CAP: capture `rx_fifo_rd_data` into `prdata`, `pready`=1. Go to IDLE.
- Illegal state: return to IDLE.

**Rules**
- Exactly one FIFO strobe per completed transfer. No strobe on setup-only or aborted phases.
- When a sticky bit's set event and its W1C clear land in the same cycle, set wins.

## Timing

**Reset values** (asynchronous assert, synchronous deassert)
- All FIFO strobes 0, `prdata`=0, `pready`=1, `pslverr`=0, `irq`=0.
- CFG_LO=0, CFG_HI=0, CTRL=0, sticky bits 0, FSM in IDLE.

**Strobes**
- TX and config pushes: `*_wr_en` is registered. It is high in the cycle after the ACCESS cycle, with the data held stable during that cycle.

**Transfer latency**
- Writes and non-RXDATA reads: zero wait states. `pready`=1 in the first ACCESS cycle, and `pslverr` is valid in that same cycle.
- RXDATA read, non-empty: ACCESS cycle 1 has `pready`=0 with pop asserted. ACCESS cycle 2 has `pready`=1 with data.
- RXDATA read, empty: zero wait, `pslverr`=1.

**Boundary cases**
- FIFO full/empty flags are sampled in the SETUP cycle.
- Reset mid-RX_POP: the FSM returns to IDLE, and the popped byte is discarded.
- `pready` is driven 1 whenever no transfer is in progress.

## Test plan

- Reset → all outputs match the reset values above; read STATUS → 0x06 with `tx_fifo_empty`=1, `rx_fifo_empty`=1, everything else 0.
- Write TXDATA=0xA5 with the FIFO not full → one `tx_fifo_wr_en` pulse with data 0xA5, `pslverr`=0. Repeat with `tx_fifo_full`=1 → no pulse, `pslverr`=1, STATUS bit4=1; write CTRL=0x10 → bit4 clears.
- Write CFG_LO=0x0000_01B2, then CFG_HI=0x03 → one `cfg_fifo_wr_en` pulse with data 0x03_0000_01B2. Repeat with `cfg_fifo_full`=1 → no push, `pslverr`=1, CFG_OVF=1.
- RX FIFO model holding 0x5C; read RXDATA → exactly one `rx_fifo_rd_en` pulse, one wait state, `prdata`=0x5C. Read again with FIFO empty → `prdata`=0, `pslverr`=1, RX_UNF=1.
- CTRL=0x1 with `rx_fifo_empty` going 1→0 → `irq` rises one cycle later. Set CTRL=0x2 with `tx_fifo_empty`=1 → `irq`=1. Set CTRL=0 → `irq`=0.
- Assert `rstn` low during RX_POP → FSM returns to IDLE, `pready`=1, and no further pop occurs after release.

Source files
------------

// File: rtl/uart_apb_regif.sv
// ---------------------------------------------------------------------------
// uart_apb_regif
// APB3 slave register front-end for the UART physical layer. CPU register
// accesses become pushes into the TX-byte and config FIFOs and pops from the
// RX-byte FIFO. The block also holds the config staging registers, the
// interrupt enables, the sticky error flags and a registered level interrupt.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr
//                              APB3 slave port (paddr[4:2] decoded)
//   tx_fifo_full/empty         TX-byte FIFO flags
//   tx_fifo_wr_en/wr_data      TX-byte FIFO push (registered)
//   cfg_fifo_full              config FIFO full flag
//   cfg_fifo_wr_en/wr_data     config FIFO push (registered)
//   rx_fifo_empty              RX-byte FIFO empty flag
//   rx_fifo_rd_en/rd_data      RX-byte FIFO pop, data valid one cycle later
//   irq                        level interrupt
// ---------------------------------------------------------------------------
module uart_apb_regif #(
   parameter int ADDR_WIDTH        = 8,
   parameter int PHY_FIFO_WIDTH    = 8,
   parameter int CONFIG_DATA_WIDTH = 40
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_WIDTH-1:0]        paddr,
   input  logic [31:0]                  pwdata,
   output logic [31:0]                  prdata,
   output logic                         pready,
   output logic                         pslverr,
   input  logic                         tx_fifo_full,
   input  logic                         tx_fifo_empty,
   output logic                         tx_fifo_wr_en,
   output logic [PHY_FIFO_WIDTH-1:0]    tx_fifo_wr_data,
   input  logic                         cfg_fifo_full,
   output logic                         cfg_fifo_wr_en,
   output logic [CONFIG_DATA_WIDTH-1:0] cfg_fifo_wr_data,
   input  logic                         rx_fifo_empty,
   output logic                         rx_fifo_rd_en,
   input  logic [PHY_FIFO_WIDTH-1:0]    rx_fifo_rd_data,
   output logic                         irq
);

   localparam int HI_W = CONFIG_DATA_WIDTH - 32;

   localparam logic [2:0] A_TXDATA = 3'd0;
   localparam logic [2:0] A_RXDATA = 3'd1;
   localparam logic [2:0] A_CFG_LO = 3'd2;
   localparam logic [2:0] A_CFG_HI = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;
   localparam logic [2:0] A_CTRL   = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RX_POP = 2'd1,
      RX_CAP = 2'd2
   } state_t;

   state_t            state;
   logic [31:0]       cfg_lo;
   logic [HI_W-1:0]   cfg_hi;
   logic [1:0]        ctrl;
   logic              tx_ovf;
   logic              cfg_ovf;
   logic              rx_unf;
   logic [31:0]       prdata_q;
   logic [31:0]       rd_val;

   // Actions decoded in SETUP and carried out only if the ACCESS cycle follows.
   logic              op_tx_push;
   logic              op_tx_ovf;
   logic              op_cfg_lo;
   logic              op_cfg_hi;
   logic              op_cfg_push;
   logic              op_cfg_ovf;
   logic              op_rx_unf;
   logic              op_ctrl;

   logic              setup_ph;
   logic              access_ph;
   logic [2:0]        reg_sel;
   logic              unused_bits;

   assign setup_ph  = psel & ~penable;
   assign access_ph = psel & penable;
   assign reg_sel   = paddr[4:2];

   assign unused_bits = ^{paddr, pwdata};

   // In RX_CAP the FIFO's read data is already valid, so it is forwarded
   // straight onto the bus to finish the read without a third wait cycle.
   assign prdata = (state == RX_CAP) ? 32'(rx_fifo_rd_data) : prdata_q;

   // Read mux for the registers served zero-wait.
   always_comb begin
      rd_val = '0;
      case (reg_sel)
         A_CFG_LO: rd_val = cfg_lo;
         A_CFG_HI: rd_val = 32'(cfg_hi);
         A_STATUS: rd_val = {25'd0, rx_unf, cfg_ovf, tx_ovf, cfg_fifo_full,
                             rx_fifo_empty, tx_fifo_empty, tx_fifo_full};
         A_CTRL:   rd_val = {30'd0, ctrl};
         default:  rd_val = '0;
      endcase
   end

   // Single control process: SETUP decodes and pre-registers the response,
   // ACCESS commits register writes, FIFO pushes and sticky flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= IDLE;
         cfg_lo           <= '0;
         cfg_hi           <= '0;
         ctrl             <= '0;
         tx_ovf           <= 1'b0;
         cfg_ovf          <= 1'b0;
         rx_unf           <= 1'b0;
         prdata_q         <= '0;
         pready           <= 1'b1;
         pslverr          <= 1'b0;
         tx_fifo_wr_en    <= 1'b0;
         tx_fifo_wr_data  <= '0;
         cfg_fifo_wr_en   <= 1'b0;
         cfg_fifo_wr_data <= '0;
         rx_fifo_rd_en    <= 1'b0;
         irq              <= 1'b0;
         op_tx_push       <= 1'b0;
         op_tx_ovf        <= 1'b0;
         op_cfg_lo        <= 1'b0;
         op_cfg_hi        <= 1'b0;
         op_cfg_push      <= 1'b0;
         op_cfg_ovf       <= 1'b0;
         op_rx_unf        <= 1'b0;
         op_ctrl          <= 1'b0;
      end else begin
         tx_fifo_wr_en  <= 1'b0;
         cfg_fifo_wr_en <= 1'b0;
         op_tx_push     <= 1'b0;
         op_tx_ovf      <= 1'b0;
         op_cfg_lo      <= 1'b0;
         op_cfg_hi      <= 1'b0;
         op_cfg_push    <= 1'b0;
         op_cfg_ovf     <= 1'b0;
         op_rx_unf      <= 1'b0;
         op_ctrl        <= 1'b0;
         irq <= (ctrl[0] & ~rx_fifo_empty) | (ctrl[1] & tx_fifo_empty);

         case (state)
            IDLE: begin
               if (access_ph) begin
                  if (op_tx_push) begin
                     tx_fifo_wr_en   <= 1'b1;
                     tx_fifo_wr_data <= pwdata[PHY_FIFO_WIDTH-1:0];
                  end
                  if (op_cfg_lo) cfg_lo <= pwdata;
                  if (op_cfg_hi) cfg_hi <= pwdata[HI_W-1:0];
                  if (op_cfg_push) begin
                     cfg_fifo_wr_en   <= 1'b1;
                     cfg_fifo_wr_data <= {pwdata[HI_W-1:0], cfg_lo};
                  end
                  if (op_ctrl) ctrl <= pwdata[1:0];
                  // Set terms are ORed last so a set beats a same-cycle clear.
                  tx_ovf  <= (tx_ovf  & ~(op_ctrl & pwdata[4])) | op_tx_ovf;
                  cfg_ovf <= (cfg_ovf & ~(op_ctrl & pwdata[5])) | op_cfg_ovf;
                  rx_unf  <= (rx_unf  & ~(op_ctrl & pwdata[6])) | op_rx_unf;
                  prdata_q <= '0;
                  pslverr  <= 1'b0;
               end else if (setup_ph) begin
                  prdata_q <= '0;
                  pslverr  <= 1'b0;
                  if (pwrite) begin
                     case (reg_sel)
                        A_TXDATA: begin
                           if (tx_fifo_full) begin
                              pslverr   <= 1'b1;
                              op_tx_ovf <= 1'b1;
                           end else begin
                              op_tx_push <= 1'b1;
                           end
                        end
                        A_CFG_LO: op_cfg_lo <= 1'b1;
                        A_CFG_HI: begin
                           op_cfg_hi <= 1'b1;
                           if (cfg_fifo_full) begin
                              pslverr    <= 1'b1;
                              op_cfg_ovf <= 1'b1;
                           end else begin
                              op_cfg_push <= 1'b1;
                           end
                        end
                        A_CTRL:   op_ctrl <= 1'b1;
                        default:  ;
                     endcase
                  end else if (reg_sel == A_RXDATA) begin
                     if (rx_fifo_empty) begin
                        pslverr   <= 1'b1;
                        op_rx_unf <= 1'b1;
                     end else begin
                        // Pop during the first ACCESS cycle, data next cycle.
                        state         <= RX_POP;
                        pready        <= 1'b0;
                        rx_fifo_rd_en <= 1'b1;
                     end
                  end else begin
                     prdata_q <= rd_val;
                  end
               end
            end
            RX_POP: begin
               rx_fifo_rd_en <= 1'b0;
               pready        <= 1'b1;
               state         <= RX_CAP;
            end
            RX_CAP: begin
               prdata_q <= '0;
               state    <= IDLE;
            end
            default: begin
               rx_fifo_rd_en <= 1'b0;
               pready        <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule
